// File: rtl/fetch_sequencer_if.sv
// Fetch sequencer bus bundle: instruction-memory request/response, execute redirect and decode hand-off.
// The master side is the sequencer; the slave side is the surrounding pipeline and memory.
interface fetch_sequencer_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        misalign_fault;

    modport master (
        output imem_req_valid, imem_addr, if_valid, if_pc, if_instr, misalign_fault,
        input  imem_req_ready, imem_resp_valid, imem_resp_data, redirect_valid, redirect_target, if_ready
    );

    modport slave (
        input  imem_req_valid, imem_addr, if_valid, if_pc, if_instr, misalign_fault,
        output imem_req_ready, imem_resp_valid, imem_resp_data, redirect_valid, redirect_target, if_ready
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Purpose: owns the PC, issues one imem fetch at a time and hands the instruction to decode (FETCH_MISALIGN_TRAP_EN adds a misaligned-redirect trap).
// Latency: request -> decode presentation >= 2 cycles; at most one instruction every 3 cycles.
// Backpressure: imem_req_ready stalls FETCH with address held; if_ready stalls HOLD; redirects override both.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               reset,
    fetch_sequencer_if.master  bus
);

    typedef enum logic [2:0] {
        S_FETCH = 3'd0,
        S_WAIT  = 3'd1,
        S_HOLD  = 3'd2,
        S_DRAIN = 3'd3
`ifdef FETCH_MISALIGN_TRAP_EN
        , S_FAULT = 3'd4
`endif
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt;
    logic [31:0] req_pc;
    logic [31:0] if_pc_q, if_instr_q;
    logic        req_fire;
    logic        capture;
    logic        take_req_pc;
    logic [31:0] redir_pc;
    logic        redir_load;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic redir_bad;
    assign redir_bad  = bus.redirect_valid && (bus.redirect_target[1:0] != 2'b00);
    assign redir_pc   = bus.redirect_target;
    assign redir_load = bus.redirect_valid && !redir_bad;
`else
    assign redir_pc   = bus.redirect_target & ~32'd3;
    assign redir_load = bus.redirect_valid;
`endif

    assign bus.imem_req_valid = !reset && (state == S_FETCH);
    assign bus.imem_addr      = pc;
    assign req_fire           = bus.imem_req_valid && bus.imem_req_ready;
    // A redirect suppresses the decode handshake in the same cycle.
    assign bus.if_valid       = !reset && (state == S_HOLD) && !bus.redirect_valid;
    assign bus.if_pc          = if_pc_q;
    assign bus.if_instr       = if_instr_q;

`ifdef FETCH_MISALIGN_TRAP_EN
    assign bus.misalign_fault = (state == S_FAULT);
`else
    assign bus.misalign_fault = 1'b0;
`endif

    always_comb begin
        state_nxt   = state;
        pc_nxt      = pc;
        capture     = 1'b0;
        take_req_pc = 1'b0;
        case (state)
            S_FETCH: begin
                if (bus.redirect_valid) begin
                    state_nxt = req_fire ? S_DRAIN : S_FETCH;
                end else if (req_fire) begin
                    state_nxt   = S_WAIT;
                    pc_nxt      = pc + 32'd4;
                    take_req_pc = 1'b1;
                end
            end
            S_WAIT: begin
                if (bus.redirect_valid) begin
                    state_nxt = bus.imem_resp_valid ? S_FETCH : S_DRAIN;
                end else if (bus.imem_resp_valid) begin
                    state_nxt = S_HOLD;
                    capture   = 1'b1;
                end
            end
            S_HOLD: begin
                if (bus.redirect_valid || bus.if_ready) begin
                    state_nxt = S_FETCH;
                end
            end
            S_DRAIN: begin
                if (!bus.redirect_valid && bus.imem_resp_valid) begin
                    state_nxt = S_FETCH;
                end
            end
`ifdef FETCH_MISALIGN_TRAP_EN
            S_FAULT: state_nxt = S_FAULT;
`endif
            default: state_nxt = S_FETCH;
        endcase

        if (redir_load) begin
            pc_nxt = redir_pc;
        end
`ifdef FETCH_MISALIGN_TRAP_EN
        // Trap wins over everything; any outstanding response is ignored in FAULT.
        if (redir_bad) begin
            state_nxt = S_FAULT;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_FETCH;
            pc         <= RESET_PC;
            req_pc     <= 32'd0;
            if_pc_q    <= 32'd0;
            if_instr_q <= 32'd0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            if (take_req_pc) begin
                req_pc <= pc;
            end
            if (capture) begin
                if_pc_q    <= req_pc;
                if_instr_q <= bus.imem_resp_data;
            end
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: memory responder with programmable latency and a scoreboard of expected decode PCs.
module tb_fetch_sequencer;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   lat = 1;
    logic [31:0] exp_q[$];

    fetch_sequencer_if bus();

    fetch_sequencer #(.RESET_PC(32'h0000_0000)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // Memory: one outstanding request, response pulse 'lat' cycles after acceptance.
    initial begin : responder
        logic        pend;
        int          cnt;
        logic [31:0] paddr;
        pend = 1'b0;
        cnt = 0;
        paddr = 32'd0;
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data  = 32'd0;
        forever begin
            @(negedge clk);
            #1;
            bus.imem_resp_valid = 1'b0;
            if (reset) begin
                pend = 1'b0;
            end else if (pend) begin
                if (cnt <= 1) begin
                    bus.imem_resp_valid = 1'b1;
                    bus.imem_resp_data  = mem_word(paddr);
                    pend = 1'b0;
                end else begin
                    cnt = cnt - 1;
                end
            end
            if (!reset && bus.imem_req_valid && bus.imem_req_ready) begin
                pend  = 1'b1;
                cnt   = lat;
                paddr = bus.imem_addr;
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        exp_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_hs(output logic got, output logic [31:0] pc, output logic [31:0] ins, output int at);
        got = 1'b0;
        pc = 32'd0;
        ins = 32'd0;
        at = 0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            #2;
            if (bus.if_valid && bus.if_ready) begin
                got = 1'b1;
                pc  = bus.if_pc;
                ins = bus.if_instr;
                at  = cyc;
            end
        end
    endtask

    task automatic test_reset();
        bus.imem_req_ready  = 1'b0;
        bus.redirect_valid  = 1'b0;
        bus.redirect_target = 32'd0;
        bus.if_ready        = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        #2;
        n_cmp++; if (bus.imem_req_valid !== 1'b0) begin n_err++; $display("FAIL reset_req_valid got %b want 0", bus.imem_req_valid); end
        n_cmp++; if (bus.if_valid !== 1'b0) begin n_err++; $display("FAIL reset_if_valid got %b want 0", bus.if_valid); end
        n_cmp++; if (bus.if_pc !== 32'd0) begin n_err++; $display("FAIL reset_if_pc got %h want 0", bus.if_pc); end
        n_cmp++; if (bus.if_instr !== 32'd0) begin n_err++; $display("FAIL reset_if_instr got %h want 0", bus.if_instr); end
        n_cmp++; if (bus.misalign_fault !== 1'b0) begin n_err++; $display("FAIL reset_fault got %b want 0", bus.misalign_fault); end
        n_cmp++; if (bus.imem_addr !== 32'd0) begin n_err++; $display("FAIL reset_addr got %h want 0", bus.imem_addr); end
        bus.imem_req_ready = 1'b1;
        bus.if_ready = 1'b1;
        #1;
        n_cmp++; if (bus.imem_req_valid !== 1'b0) begin n_err++; $display("FAIL reset_req_valid_ready got %b want 0", bus.imem_req_valid); end
        n_cmp++; if (bus.if_valid !== 1'b0) begin n_err++; $display("FAIL reset_if_valid_ready got %b want 0", bus.if_valid); end
    endtask

    task automatic test_stream();
        logic got; logic [31:0] pc, ins, e; int at, prev;
        lat = 1; bus.imem_req_ready = 1'b1; bus.if_ready = 1'b1;
        do_reset();
        exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h8);
        prev = 0;
        for (int k = 0; k < 3; k++) begin
            wait_hs(got, pc, ins, at);
            e = exp_q.pop_front();
            n_cmp++;
            if (!got) begin n_err++; $display("FAIL stream_timeout got none want pc %h", e); end
            else begin
                if (pc !== e) begin n_err++; $display("FAIL stream_pc got %h want %h", pc, e); end
                n_cmp++; if (ins !== mem_word(e)) begin n_err++; $display("FAIL stream_instr got %h want %h", ins, mem_word(e)); end
                if (k > 0) begin
                    n_cmp++; if (at - prev != 3) begin n_err++; $display("FAIL stream_gap got %0d want 3", at - prev); end
                end
            end
            prev = at;
        end
    endtask

    task automatic test_backpressure();
        logic got; logic [31:0] pc, ins, e; int at;
        lat = 1; bus.imem_req_ready = 1'b1; bus.if_ready = 1'b1;
        do_reset();
        wait_hs(got, pc, ins, at);
        n_cmp++; if (!got || pc !== 32'h0) begin n_err++; $display("FAIL bp_first got %h (seen %b) want 0", pc, got); end
        bus.imem_req_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #2;
            n_cmp++; if (bus.imem_req_valid !== 1'b1) begin n_err++; $display("FAIL bp_req_valid cycle %0d got %b want 1", i, bus.imem_req_valid); end
            n_cmp++; if (bus.imem_addr !== 32'h4) begin n_err++; $display("FAIL bp_addr cycle %0d got %h want 4", i, bus.imem_addr); end
        end
        @(negedge clk);
        bus.imem_req_ready = 1'b1;
        exp_q.push_back(32'h4);
        wait_hs(got, pc, ins, at);
        e = exp_q.pop_front();
        n_cmp++; if (!got || pc !== e || ins !== mem_word(e)) begin n_err++; $display("FAIL bp_resume got pc %h instr %h want pc %h instr %h", pc, ins, e, mem_word(e)); end
    endtask

    task automatic test_redirect_wait();
        logic got; logic [31:0] pc, ins, e; int at;
        lat = 2; bus.imem_req_ready = 1'b1; bus.if_ready = 1'b1;
        do_reset();
        @(negedge clk);
        bus.redirect_valid = 1'b1; bus.redirect_target = 32'h100;
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        #2;
        n_cmp++; if (bus.imem_req_valid !== 1'b0) begin n_err++; $display("FAIL drain_req_valid got %b want 0", bus.imem_req_valid); end
        n_cmp++; if (bus.imem_addr !== 32'h100) begin n_err++; $display("FAIL drain_addr got %h want 100", bus.imem_addr); end
        exp_q.push_back(32'h100);
        wait_hs(got, pc, ins, at);
        e = exp_q.pop_front();
        n_cmp++; if (!got || pc !== e) begin n_err++; $display("FAIL redir_wait_pc got %h (seen %b) want %h", pc, got, e); end
        n_cmp++; if (ins !== mem_word(e)) begin n_err++; $display("FAIL redir_wait_instr got %h want %h", ins, mem_word(e)); end
    endtask

    task automatic test_redirect_hold();
        logic got; logic [31:0] pc, ins, e; int at;
        lat = 1; bus.imem_req_ready = 1'b1; bus.if_ready = 1'b0;
        do_reset();
        @(negedge clk);
        @(negedge clk);
        bus.if_ready = 1'b1; bus.redirect_valid = 1'b1; bus.redirect_target = 32'h200;
        #2;
        n_cmp++; if (bus.if_valid !== 1'b0) begin n_err++; $display("FAIL hold_redir_if_valid got %b want 0", bus.if_valid); end
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        #2;
        n_cmp++; if (bus.imem_req_valid !== 1'b1 || bus.imem_addr !== 32'h200) begin n_err++; $display("FAIL hold_refetch got valid %b addr %h want 1 200", bus.imem_req_valid, bus.imem_addr); end
        exp_q.push_back(32'h200);
        wait_hs(got, pc, ins, at);
        e = exp_q.pop_front();
        n_cmp++; if (!got || pc !== e || ins !== mem_word(e)) begin n_err++; $display("FAIL hold_next got pc %h instr %h want pc %h instr %h", pc, ins, e, mem_word(e)); end
    endtask

    task automatic test_wrap();
        logic got; logic [31:0] pc, ins, e; int at;
        lat = 1; bus.imem_req_ready = 1'b0; bus.if_ready = 1'b1;
        do_reset();
        @(negedge clk);
        bus.redirect_valid = 1'b1; bus.redirect_target = 32'hFFFF_FFFC;
        @(negedge clk);
        bus.redirect_valid = 1'b0; bus.imem_req_ready = 1'b1;
        #2;
        n_cmp++; if (bus.imem_req_valid !== 1'b1 || bus.imem_addr !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_req got valid %b addr %h want 1 fffffffc", bus.imem_req_valid, bus.imem_addr); end
        @(negedge clk);
        #2;
        n_cmp++; if (bus.imem_addr !== 32'h0) begin n_err++; $display("FAIL wrap_pc got %h want 0", bus.imem_addr); end
        exp_q.push_back(32'hFFFF_FFFC); exp_q.push_back(32'h0);
        for (int k = 0; k < 2; k++) begin
            wait_hs(got, pc, ins, at);
            e = exp_q.pop_front();
            n_cmp++; if (!got || pc !== e || ins !== mem_word(e)) begin n_err++; $display("FAIL wrap_seq%0d got pc %h instr %h want pc %h instr %h", k, pc, ins, e, mem_word(e)); end
        end
    endtask

    task automatic test_misalign();
        lat = 1; bus.imem_req_ready = 1'b0; bus.if_ready = 1'b1;
        do_reset();
        @(negedge clk);
        bus.redirect_valid = 1'b1; bus.redirect_target = 32'h102;
        @(negedge clk);
        bus.redirect_valid = 1'b0; bus.imem_req_ready = 1'b1;
        #2;
`ifdef FETCH_MISALIGN_TRAP_EN
        begin
            int act;
            n_cmp++; if (bus.misalign_fault !== 1'b1) begin n_err++; $display("FAIL trap_fault got %b want 1", bus.misalign_fault); end
            n_cmp++; if (bus.imem_req_valid !== 1'b0) begin n_err++; $display("FAIL trap_req_valid got %b want 0", bus.imem_req_valid); end
            act = 0;
            for (int i = 0; i < 8; i++) begin
                @(negedge clk);
                #2;
                if (bus.imem_req_valid || bus.if_valid || !bus.misalign_fault) act++;
            end
            n_cmp++; if (act != 0) begin n_err++; $display("FAIL trap_sticky active cycles got %0d want 0", act); end
            @(negedge clk);
            reset = 1'b1;
            @(negedge clk);
            reset = 1'b0;
            #2;
            n_cmp++; if (bus.misalign_fault !== 1'b0 || bus.imem_req_valid !== 1'b1 || bus.imem_addr !== 32'h0) begin n_err++; $display("FAIL trap_clear got fault %b valid %b addr %h want 0 1 0", bus.misalign_fault, bus.imem_req_valid, bus.imem_addr); end
        end
`else
        begin
            logic got; logic [31:0] pc, ins, e; int at;
            n_cmp++; if (bus.misalign_fault !== 1'b0) begin n_err++; $display("FAIL noTrap_fault got %b want 0", bus.misalign_fault); end
            n_cmp++; if (bus.imem_req_valid !== 1'b1 || bus.imem_addr !== 32'h100) begin n_err++; $display("FAIL noTrap_req got valid %b addr %h want 1 100", bus.imem_req_valid, bus.imem_addr); end
            exp_q.push_back(32'h100);
            wait_hs(got, pc, ins, at);
            e = exp_q.pop_front();
            n_cmp++; if (!got || pc !== e || ins !== mem_word(e)) begin n_err++; $display("FAIL noTrap_fetch got pc %h instr %h want pc %h instr %h", pc, ins, e, mem_word(e)); end
        end
`endif
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_wait();
        test_redirect_hold();
        test_wrap();
        test_misalign();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
